// File: rtl/consmax_pkg.sv
// Shared sizing defaults and lane-slice helper for the ConSmax row packer.
package consmax_pkg;

  localparam int IDATA_BIT_DEF = 8;
  localparam int ROW_LEN_DEF   = 8;
  localparam int CNT_BIT_DEF   = $clog2(ROW_LEN_DEF + 1);

  // Bit offset of lane k inside a packed row of w-bit elements.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/consmax_row_bank.sv
// One row buffer: element lanes, full flag and row length.
// Latency: write/close visible after the clock edge; clear takes effect at the edge.
// Backpressure: none; the owner must not write a full bank.
module consmax_row_bank
  import consmax_pkg::*;
#(
  parameter int IDATA_BIT = IDATA_BIT_DEF,
  parameter int ROW_LEN   = ROW_LEN_DEF,
  parameter int CNT_BIT   = $clog2(ROW_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [CNT_BIT-1:0]           wr_lane,
  input  logic [IDATA_BIT-1:0]         wr_data,
  input  logic                         close,
  input  logic [CNT_BIT-1:0]           close_len,
  input  logic                         clr,
  output logic [ROW_LEN*IDATA_BIT-1:0] row,
  output logic [CNT_BIT-1:0]           len,
  output logic                         full
);

  logic [IDATA_BIT-1:0] lane_q [ROW_LEN];

  // Lanes are zeroed on clear so a later partial row leaves its tail at 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < ROW_LEN; k++) lane_q[k] <= '0;
      full <= 1'b0;
      len  <= '0;
    end else begin
      for (int k = 0; k < ROW_LEN; k++) begin
        if (wr_en && (wr_lane == CNT_BIT'(k))) lane_q[k] <= wr_data;
      end
      if (close) begin
        full <= 1'b1;
        len  <= close_len;
      end
    end
  end

  for (genvar k = 0; k < ROW_LEN; k++) begin : g_lane
    assign row[lane_lsb(k, IDATA_BIT) +: IDATA_BIT] = lane_q[k];
  end

endmodule

// File: rtl/consmax_row_packer.sv
// Packs the serial ConSmax score stream into row-wide beats via two ping-pong banks.
// Latency: beat valid the cycle after the closing element (or flush) is written.
// Backpressure: input has none; elements arriving with no free bank are dropped and flagged.
module consmax_row_packer
  import consmax_pkg::*;
#(
  parameter int IDATA_BIT = IDATA_BIT_DEF,
  parameter int ROW_LEN   = ROW_LEN_DEF,
  parameter int CNT_BIT   = $clog2(ROW_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CNT_BIT-1:0]           cfg_row_len,
  input  logic [IDATA_BIT-1:0]         idata,
  input  logic                         idata_valid,
  input  logic                         flush,
  output logic [ROW_LEN*IDATA_BIT-1:0] odata,
  output logic [CNT_BIT-1:0]           odata_len,
  output logic                         odata_valid,
  input  logic                         odata_ready,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam logic [CNT_BIT-1:0] ROW_LEN_C = CNT_BIT'(ROW_LEN);

  logic                         wr_sel, rd_sel;
  logic [CNT_BIT-1:0]           wr_idx, row_len_q;
  logic [CNT_BIT-1:0]           eff_len, cur_len, close_len, wr_idx_inc;
  logic                         sel_full, wr_ok, drop, close_wr, close_fl, close_any, accept;
  logic [1:0]                   bank_full;
  logic [ROW_LEN*IDATA_BIT-1:0] bank_row [2];
  logic [CNT_BIT-1:0]           bank_len [2];

  assign eff_len    = ((cfg_row_len == '0) || (cfg_row_len > ROW_LEN_C)) ? ROW_LEN_C : cfg_row_len;
  // The first element of a row uses the live config; later ones use the latched length.
  assign cur_len    = (wr_idx == '0) ? eff_len : row_len_q;
  assign wr_idx_inc = wr_idx + CNT_BIT'(1);

  assign sel_full  = bank_full[wr_sel];
  assign wr_ok     = idata_valid && !sel_full;
  assign drop      = idata_valid && sel_full;
  assign close_wr  = wr_ok && ((wr_idx_inc == cur_len) || flush);
  assign close_fl  = !idata_valid && flush && (wr_idx != '0);
  assign close_any = close_wr || close_fl;
  assign close_len = close_wr ? wr_idx_inc : wr_idx;

  assign odata_valid = bank_full[rd_sel];
  assign odata       = bank_row[rd_sel];
  assign odata_len   = bank_len[rd_sel];
  assign accept      = odata_valid && odata_ready;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    consmax_row_bank #(
      .IDATA_BIT (IDATA_BIT),
      .ROW_LEN   (ROW_LEN),
      .CNT_BIT   (CNT_BIT)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_ok && (wr_sel == 1'(i))),
      .wr_lane   (wr_idx),
      .wr_data   (idata),
      .close     (close_any && (wr_sel == 1'(i))),
      .close_len (close_len),
      .clr       (accept && (rd_sel == 1'(i))),
      .row       (bank_row[i]),
      .len       (bank_len[i]),
      .full      (bank_full[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_idx    <= '0;
      row_len_q <= ROW_LEN_C;
      overflow  <= 1'b0;
    end else begin
      if (wr_ok && (wr_idx == '0)) row_len_q <= eff_len;
      if (close_any) begin
        wr_sel <= ~wr_sel;
        wr_idx <= '0;
      end else if (wr_ok) begin
        wr_idx <= wr_idx_inc;
      end
      if (accept) rd_sel <= ~rd_sel;
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_consmax_row_packer.sv
// Scoreboard bench for consmax_row_packer: expected beats queued at stimulus, popped on accept.
module tb_consmax_row_packer;

  localparam int IB = 8;
  localparam int RL = 8;
  localparam int CB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [CB-1:0]  cfg_row_len = 4'd8;
  logic [IB-1:0]  idata = '0;
  logic           idata_valid = 1'b0;
  logic           flush = 1'b0;
  logic [RL*IB-1:0] odata;
  logic [CB-1:0]  odata_len;
  logic           odata_valid;
  logic           odata_ready = 1'b0;
  logic           overflow;
  logic           ovf_clr = 1'b0;

  typedef struct packed {
    logic [63:0] dat;
    logic [3:0]  len;
  } beat_t;

  beat_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  consmax_row_packer dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_row_len (cfg_row_len),
    .idata       (idata),
    .idata_valid (idata_valid),
    .flush       (flush),
    .odata       (odata),
    .odata_len   (odata_len),
    .odata_valid (odata_valid),
    .odata_ready (odata_ready),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_row(input int base, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*8 +: 8] = 8'(base + k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int base, input int n);
    beat_t b;
    b.dat = mk_row(base, n);
    b.len = 4'(n);
    exp_q.push_back(b);
  endtask

  task automatic send(input int v);
    idata       = 8'(v);
    idata_valid = 1'b1;
    step();
    idata_valid = 1'b0;
  endtask

  task automatic send_row(input int base, input int n);
    for (int i = 0; i < n; i++) send(base + i);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  // Accepted beats are compared against the head of the scoreboard.
  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst && odata_valid && odata_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          b = exp_q.pop_front();
          check("beat_dat", odata, b.dat);
          check("beat_len", 64'(odata_len), 64'(b.len));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 64'(odata_valid), 64'd0);
    check("rst_dat", odata, 64'd0);
    check("rst_len", 64'(odata_len), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);

    // Basic 4-element row, latency to valid.
    cfg_row_len = 4'd4;
    odata_ready = 1'b1;
    push_beat(1, 4);
    send_row(1, 3);
    check("t1_not_yet", 64'(odata_valid), 64'd0);
    send(4);
    check("t1_latency", 64'(odata_valid), 64'd1);
    drain(4);
    check("t1_idle", 64'(odata_valid), 64'd0);

    // Both banks fill under stall, then a drop.
    cfg_row_len = 4'd8;
    odata_ready = 1'b0;
    push_beat(8'h11, 8);
    push_beat(8'h21, 8);
    send_row(8'h11, 8);
    send_row(8'h21, 8);
    check("t2_valid", 64'(odata_valid), 64'd1);
    check("t2_no_ovf", 64'(overflow), 64'd0);
    step();
    step();
    check("t2_stall_dat", odata, mk_row(8'h11, 8));
    check("t2_stall_len", 64'(odata_len), 64'd8);
    send(8'h99);
    check("t2_ovf", 64'(overflow), 64'd1);
    check("t2_after_drop_dat", odata, mk_row(8'h11, 8));
    odata_ready = 1'b1;
    drain(6);
    check("t2_idle", 64'(odata_valid), 64'd0);
    check("t2_ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t2_ovf_clr", 64'(overflow), 64'd0);

    // Flush closes a partial row; flush on an empty row does nothing.
    push_beat(8'h31, 3);
    send_row(8'h31, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drain(4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    check("t3_empty_flush", 64'(odata_valid), 64'd0);

    // Mid-row config change only affects the next row.
    cfg_row_len = 4'd4;
    push_beat(8'h41, 4);
    push_beat(8'h45, 2);
    send(8'h41);
    send(8'h42);
    cfg_row_len = 4'd2;
    send(8'h43);
    check("t4_no_early_close", 64'(odata_valid), 64'd0);
    send(8'h44);
    send(8'h45);
    send(8'h46);
    drain(4);

    // Reset discards a full bank and a partial row.
    cfg_row_len = 4'd8;
    odata_ready = 1'b0;
    send_row(8'h51, 8);
    send_row(8'h61, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", 64'(odata_valid), 64'd0);
    check("t5_dat", odata, 64'd0);
    check("t5_len", 64'(odata_len), 64'd0);
    odata_ready = 1'b1;
    push_beat(8'h71, 8);
    send_row(8'h71, 8);
    drain(4);

    // Accept of B0 coincides with the closing write of B1.
    cfg_row_len = 4'd4;
    odata_ready = 1'b0;
    push_beat(8'h81, 4);
    push_beat(8'h91, 4);
    send_row(8'h81, 4);
    send_row(8'h91, 3);
    odata_ready = 1'b1;
    send(8'h94);
    check("t6_b1_follow", 64'(odata_valid), 64'd1);
    check("t6_b1_dat", odata, mk_row(8'h91, 4));
    drain(3);
    check("t6_idle", 64'(odata_valid), 64'd0);

    // Drop wins over ovf_clr in the same cycle.
    cfg_row_len = 4'd2;
    odata_ready = 1'b0;
    push_beat(8'hA1, 2);
    push_beat(8'hA3, 2);
    send_row(8'hA1, 4);
    ovf_clr = 1'b1;
    send(8'hFF);
    ovf_clr = 1'b0;
    check("t7_set_wins", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t7_clr", 64'(overflow), 64'd0);
    odata_ready = 1'b1;
    drain(4);

    // Out-of-range lengths mean ROW_LEN; length 1 streams with no bubbles.
    cfg_row_len = 4'd0;
    push_beat(8'hB1, 8);
    send_row(8'hB1, 8);
    drain(3);
    cfg_row_len = 4'd9;
    push_beat(8'hD1, 8);
    send_row(8'hD1, 8);
    drain(3);
    cfg_row_len = 4'd1;
    for (int i = 0; i < 6; i++) push_beat(8'hC1 + i, 1);
    send_row(8'hC1, 6);
    drain(2);
    check("t8_no_ovf", 64'(overflow), 64'd0);

    step();
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
